// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_control_unit
// Purpose  : Instruction sequencer for the 8-bit CPU. Fetches an instruction
//            from the unified memory, decodes it, drives the combinational
//            ALU and owns the A/B/PC/IR registers and the {v,z,n} flags.
// Options  : CTRL_OVF_TRAP_EN - when defined, an ALU overflow in EXEC halts
//            the sequencer with ovf_trap=1 after A and flags are updated.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_control_unit #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  // unified memory, req/ready handshake
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ready,
  // combinational ALU
  output logic [3:0]        alu_opcode,
  output logic [WIDTH-1:0]  alu_in_A,
  output logic [WIDTH-1:0]  alu_in_B,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              overflow,
  input  logic              zero,
  input  logic              negative,
  // status / debug
  output logic              halted,
  output logic              ovf_trap,
  output logic [AWIDTH-1:0] pc_out,
  output logic [WIDTH-1:0]  acc_out
);

  // Sequencer states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_EXEC   = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  // Instruction opcodes (IR upper nibble); anything else decodes as NOP
  localparam logic [3:0] OP_HALT     = 4'b0000;
  localparam logic [3:0] OP_LOAD_B   = 4'b0001;
  localparam logic [3:0] OP_LOAD_A   = 4'b0010;
  localparam logic [3:0] OP_STORE_A  = 4'b0100;
  localparam logic [3:0] OP_ADD      = 4'b1000;
  localparam logic [3:0] OP_SUB      = 4'b1001;
  localparam logic [3:0] OP_JUMP     = 4'b1010;
  localparam logic [3:0] OP_JUMP_NEG = 4'b1011;

  localparam logic [AWIDTH-1:0] PC_ONE = AWIDTH'(1);

  state_t              state;
  logic [AWIDTH-1:0]   pc;
  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;
  logic [WIDTH-1:0]    ir;
  logic                flag_v;
  logic                flag_z;
  logic                flag_n;

  logic [3:0]          opcode;
  logic [AWIDTH-1:0]   operand_addr;
  logic [AWIDTH-1:0]   branch_target;

  assign opcode       = ir[WIDTH-1 -: 4];
  assign operand_addr = ir[AWIDTH-1:0];

  assign alu_in_A = a_reg;
  assign alu_in_B = b_reg;
  assign pc_out   = pc;
  assign acc_out  = a_reg;

  // v and z are architectural state but nothing inside the sequencer
  // branches on them; keep them visibly consumed.
  logic unused_flags;
  assign unused_flags = flag_v ^ flag_z;

`ifdef CTRL_OVF_TRAP_EN
  logic trap_reg;
  assign ovf_trap = trap_reg;
`else
  assign ovf_trap = 1'b0;
`endif

  // Address of the next fetch after DECODE: jump target, taken
  // negative-branch target, or the already-incremented PC (fall-through/NOP).
  always_comb begin
    branch_target = pc;
    case (opcode)
      OP_JUMP:     branch_target = operand_addr;
      OP_JUMP_NEG: if (flag_n) branch_target = operand_addr;
      default:     branch_target = pc;
    endcase
  end

  // Main sequencer: state, architectural registers and registered outputs.
  // Memory requests are raised on the transition into the requesting state,
  // so mem_addr/mem_wdata are registered and stay put while a request waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      ir         <= '0;
      flag_v     <= 1'b0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      halted     <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      alu_opcode <= 4'b0000;
`ifdef CTRL_OVF_TRAP_EN
      trap_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem_re) begin
            // First cycle out of reset: no request is pending yet, so
            // mem_ready is meaningless here; raise the fetch request.
            mem_re   <= 1'b1;
            mem_addr <= pc;
          end else if (mem_ready) begin
            ir     <= mem_rdata;
            pc     <= pc + PC_ONE;
            mem_re <= 1'b0;
            state  <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (opcode)
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALTED;
            end
            OP_LOAD_A, OP_LOAD_B: begin
              mem_re   <= 1'b1;
              mem_addr <= operand_addr;
              state    <= S_MEM_RD;
            end
            OP_STORE_A: begin
              mem_we    <= 1'b1;
              mem_addr  <= operand_addr;
              mem_wdata <= a_reg;
              state     <= S_MEM_WR;
            end
            OP_ADD, OP_SUB: begin
              alu_opcode <= opcode;
              state      <= S_EXEC;
            end
            default: begin
              // JUMP, JUMP_NEG and undefined opcodes all refetch from
              // branch_target; for NOP that is simply the current PC.
              pc       <= branch_target;
              mem_re   <= 1'b1;
              mem_addr <= branch_target;
              state    <= S_FETCH;
            end
          endcase
        end

        S_MEM_RD: begin
          if (mem_ready) begin
            if (opcode == OP_LOAD_A) begin
              a_reg <= mem_rdata;
            end else begin
              b_reg <= mem_rdata;
            end
            mem_re   <= 1'b1;
            mem_addr <= pc;
            state    <= S_FETCH;
          end
        end

        S_MEM_WR: begin
          if (mem_ready) begin
            mem_we   <= 1'b0;
            mem_re   <= 1'b1;
            mem_addr <= pc;
            state    <= S_FETCH;
          end
        end

        S_EXEC: begin
          a_reg      <= alu_out;
          flag_v     <= overflow;
          flag_z     <= zero;
          flag_n     <= negative;
          alu_opcode <= 4'b0000;
`ifdef CTRL_OVF_TRAP_EN
          if (overflow) begin
            halted   <= 1'b1;
            trap_reg <= 1'b1;
            state    <= S_HALTED;
          end else begin
            mem_re   <= 1'b1;
            mem_addr <= pc;
            state    <= S_FETCH;
          end
`else
          mem_re   <= 1'b1;
          mem_addr <= pc;
          state    <= S_FETCH;
`endif
        end

        S_HALTED: begin
          // Absorbing until reset; no memory traffic.
          mem_re <= 1'b0;
          mem_we <= 1'b0;
        end

        default: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          state  <= S_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
